alu_pipe_hs: RTL and testbench
==============================

Name: alu_pipe_hs

Overview:
- Parametrised, pipelined ALU with valid/ready handshake on input and output.
- Successor to the single-cycle combinational ALU and the single-register pipeline stage.
- Adds configurable width and depth, more ops, carry/zero flags and full backpressure.
- Sits between an operand source and a result consumer. Both sides use the same clock.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- STAGES, 3, pipeline depth in register stages (>=1). This is the latency from input accept to out_valid.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block can accept a beat this cycle
- op  input  3  operation select
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts result this cycle
- result  output  WIDTH  operation result
- carry  output  1  carry/borrow flag
- zero  output  1  result == 0

Behaviour:
- Reset:
  - Async assert clears every stage valid bit and every data/flag register to 0.
  - Outputs during and after reset: out_valid=0, result=0, carry=0, zero=0, in_ready=1.
  - Release is sampled at the next clk edge.
- Handshake:
  - A beat transfers on a rising edge where valid && ready.
  - in_ready does not depend on in_valid. out_valid does not depend on out_ready.
- Output stability: while out_valid=1 && out_ready=0, result/carry/zero hold stable and out_valid stays 1.
- Operation, computed in stage 0 and registered; later stages only delay:
  - 000 add: result=a+b mod 2^WIDTH, carry=unsigned carry out.
  - 001 sub: result=a-b mod 2^WIDTH, carry=1 iff a<b unsigned (borrow).
  - 010 and, 011 or, 100 xor: bitwise, carry=0.
  - 101 pass: result=a, carry=0.
  - 110 shl: result=a<<1, carry=a[WIDTH-1].
  - 111 reserved: result=0, carry=0.
  - zero=(result==0) for every op, including 111.
- Pipeline control (elastic, per stage i, 0..STAGES-1):
  - Each stage holds valid v[i] plus data.
  - Stage i can load when !v[i], or when stage i+1 can load. For the last stage, "stage i+1 can load" means out_ready.
  - in_ready = stage 0 can load.
  - A stage that loads takes upstream data and valid; upstream valid=0 creates a bubble.
  - A stage that cannot load holds its contents.
- Latency and throughput:
  - Exactly STAGES cycles from accept to out_valid when downstream never stalls.
  - Throughput 1 beat/clk with out_ready held high.
  - No beat is dropped, duplicated or reordered.
- Capacity:
  - Up to STAGES beats in flight.
  - With out_ready=0, in_ready falls once all stages are valid, i.e. after STAGES accepted beats.
  - Full and out_ready rising: in_ready=1 in the same cycle (combinational pass-through of ready). Simultaneous pop and push is allowed with no bubble.
- Bubbles: with idle input, valid bubbles collapse when the output stalls, so all stages are filled before in_ready drops.
- Reset mid-stream: all in-flight beats are discarded. No partial result appears after reset.
- STAGES=1: behaves as a single registered ALU with a one-entry skid-free handshake (in_ready = !out_valid || out_ready).

Test Plan:
- Reset mid-stream: rst pulse while 2 beats are in flight -> out_valid=0, result=0, carry=0, zero=0 during reset; no stale beat emerges afterwards.
- Ops sweep, WIDTH=8, STAGES=3, out_ready=1: add 0xF0+0x20 at cycle 0 -> cycle 3 result=0x10, carry=1, zero=0. sub 0x05-0x07 -> 0xFE, carry=1. sub 0x07-0x07 -> 0x00, carry=0, zero=1. shl 0x81 -> 0x02, carry=1. op 111 -> 0x00, zero=1.
- Throughput: 10 back-to-back add beats a=i, b=1 with out_ready=1 -> out_valid high for 10 consecutive cycles starting 3 cycles after the first accept, results 1..10 in order.
- Backpressure: out_ready=0 and continuous in_valid -> exactly 3 beats accepted, then in_ready=0. result stays at the first beat while stalled. Then out_ready=1 -> remaining beats drain in order with no loss; in_ready=1 the same cycle.
- Bubbles: in_valid toggling 1,0,1,0 with out_ready=0 -> pipeline still absorbs 3 beats before in_ready=0; output order is preserved.
- STAGES=1, WIDTH=16: 0xFFFF+0x0001 -> next cycle result=0x0000, carry=1, zero=1. Simultaneous out_ready=1 and in_valid=1 when full -> one beat in and one out per cycle.

Source files
------------

// File: rtl/alu_pipe_hs.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe_hs
// Brief    : Parametrised elastic ALU pipeline with valid/ready on both sides,
//            carry/borrow and zero flags.
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe_hs #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_AND  = 3'b010;
    localparam logic [2:0] c_OP_OR   = 3'b011;
    localparam logic [2:0] c_OP_XOR  = 3'b100;
    localparam logic [2:0] c_OP_PASS = 3'b101;
    localparam logic [2:0] c_OP_SHL  = 3'b110;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_cy;
    logic             w_alu_z;

    // Extra top bit of the difference is the unsigned borrow
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        w_alu_res = '0;
        w_alu_cy  = 1'b0;
        case (op)
            c_OP_ADD:  begin w_alu_res = w_sum[WIDTH-1:0];  w_alu_cy = w_sum[WIDTH];  end
            c_OP_SUB:  begin w_alu_res = w_diff[WIDTH-1:0]; w_alu_cy = w_diff[WIDTH]; end
            c_OP_AND:  w_alu_res = a & b;
            c_OP_OR:   w_alu_res = a | b;
            c_OP_XOR:  w_alu_res = a ^ b;
            c_OP_PASS: w_alu_res = a;
            c_OP_SHL:  begin w_alu_res = {a[WIDTH-2:0], 1'b0}; w_alu_cy = a[WIDTH-1]; end
            default:   ;
        endcase
    end

    assign w_alu_z = (w_alu_res == '0);

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] cy_q, cy_d;
    logic [STAGES-1:0] z_q, z_d;
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  res_d [STAGES];

    logic [STAGES-1:0] w_up_v, w_up_cy, w_up_z;
    logic [WIDTH-1:0]  w_up_res [STAGES];
    logic [STAGES-1:0] w_load;

    assign w_up_v[0]   = in_valid;
    assign w_up_cy[0]  = w_alu_cy;
    assign w_up_z[0]   = w_alu_z;
    assign w_up_res[0] = w_alu_res;

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_upstream
            assign w_up_v[gi]   = v_q[gi-1];
            assign w_up_cy[gi]  = cy_q[gi-1];
            assign w_up_z[gi]   = z_q[gi-1];
            assign w_up_res[gi] = res_q[gi-1];
        end
    endgenerate

    // Stage i can load unless it and every stage after it are full and the
    // consumer is stalling; flattened so no signal feeds back on itself.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            w_load[i] = out_ready;
            for (int j = i; j < STAGES; j++) begin
                if (!v_q[j]) begin
                    w_load[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        v_d   = v_q;
        cy_d  = cy_q;
        z_d   = z_q;
        res_d = res_q;
        for (int i = 0; i < STAGES; i++) begin
            if (w_load[i]) begin
                v_d[i]   = w_up_v[i];
                cy_d[i]  = w_up_cy[i];
                z_d[i]   = w_up_z[i];
                res_d[i] = w_up_res[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            cy_q  <= '0;
            z_q   <= '0;
            res_q <= '{default: '0};
        end else begin
            v_q   <= v_d;
            cy_q  <= cy_d;
            z_q   <= z_d;
            res_q <= res_d;
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = v_q[STAGES-1];
    assign result    = res_q[STAGES-1];
    assign carry     = cy_q[STAGES-1];
    assign zero      = z_q[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe_hs
// Brief    : Scoreboard bench for alu_pipe_hs (8-bit/3-stage and 16-bit/1-stage).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe_hs;

    localparam logic [2:0] c_ADD  = 3'b000;
    localparam logic [2:0] c_SUB  = 3'b001;
    localparam logic [2:0] c_AND  = 3'b010;
    localparam logic [2:0] c_OR   = 3'b011;
    localparam logic [2:0] c_XOR  = 3'b100;
    localparam logic [2:0] c_PASS = 3'b101;
    localparam logic [2:0] c_SHL  = 3'b110;
    localparam logic [2:0] c_RSV  = 3'b111;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_valid3, in_ready3, out_valid3, out_ready3, carry3, zero3;
    logic [2:0] op3;
    logic [7:0] a3, b3, result3;

    logic        in_valid1, in_ready1, out_valid1, out_ready1, carry1, zero1;
    logic [2:0]  op1;
    logic [15:0] a1, b1, result1;

    alu_pipe_hs #(.WIDTH(8), .STAGES(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
        .op(op3), .a(a3), .b(b3), .out_valid(out_valid3), .out_ready(out_ready3),
        .result(result3), .carry(carry3), .zero(zero3)
    );

    alu_pipe_hs #(.WIDTH(16), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .op(op1), .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .result(result1), .carry(carry1), .zero(zero1)
    );

    typedef struct packed {
        logic [15:0] res;
        logic        cy;
        logic        z;
        int          t;
    } exp_t;

    exp_t q3[$];
    exp_t q1[$];

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int acc3     = 0;
    bit lat3_chk = 1'b0;
    bit lat1_chk = 1'b0;

    logic [7:0]  e3_res;
    logic        e3_cy, e3_z;
    logic [15:0] e1_res;
    logic        e1_cy, e1_z;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Input side of the scoreboard: record the hand-computed expectation of each accepted beat
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid3 && in_ready3) begin
                q3.push_back('{{8'h00, e3_res}, e3_cy, e3_z, cycle});
                acc3++;
            end
            if (in_valid1 && in_ready1) begin
                q1.push_back('{e1_res, e1_cy, e1_z, cycle});
            end
        end
    end

    // Output side of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid3 && out_ready3) begin
                if (q3.size() == 0) begin
                    chk("unexpected_beat3", {24'h0, result3}, 32'hFFFF_FFFF);
                end else begin
                    e = q3.pop_front();
                    chk("result3", {24'h0, result3}, {24'h0, e.res[7:0]});
                    chk("carry3", {31'h0, carry3}, {31'h0, e.cy});
                    chk("zero3", {31'h0, zero3}, {31'h0, e.z});
                    if (lat3_chk) chk("latency3", cycle - e.t, 32'd3);
                end
            end
            if (out_valid1 && out_ready1) begin
                if (q1.size() == 0) begin
                    chk("unexpected_beat1", {16'h0, result1}, 32'hFFFF_FFFF);
                end else begin
                    e = q1.pop_front();
                    chk("result1", {16'h0, result1}, {16'h0, e.res});
                    chk("carry1", {31'h0, carry1}, {31'h0, e.cy});
                    chk("zero1", {31'h0, zero1}, {31'h0, e.z});
                    if (lat1_chk) chk("latency1", cycle - e.t, 32'd1);
                end
            end
        end
    end

    // Drivers are entered and left at posedge+1; in_valid stays high on return
    task automatic send3(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] r, input logic c, input logic z);
        int n = 0;
        in_valid3 = 1'b1; op3 = o; a3 = x; b3 = y;
        e3_res = r; e3_cy = c; e3_z = z;
        @(negedge clk);
        while (!in_ready3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready3) chk("send3_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic send1(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] r, input logic c, input logic z);
        int n = 0;
        in_valid1 = 1'b1; op1 = o; a1 = x; b1 = y;
        e1_res = r; e1_cy = c; e1_z = z;
        @(negedge clk);
        while (!in_ready1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready1) chk("send1_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle3();
        in_valid3 = 1'b0;
    endtask

    task automatic idle1();
        in_valid1 = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        rst = 1'b1;
        in_valid3 = 1'b0; op3 = '0; a3 = '0; b3 = '0; out_ready3 = 1'b1;
        in_valid1 = 1'b0; op1 = '0; a1 = '0; b1 = '0; out_ready1 = 1'b1;
        e3_res = '0; e3_cy = 1'b0; e3_z = 1'b0;
        e1_res = '0; e1_cy = 1'b0; e1_z = 1'b0;
        wait_cycles(2);
        chk("rst_out_valid", {31'h0, out_valid3}, 32'd0);
        chk("rst_result", {24'h0, result3}, 32'd0);
        chk("rst_carry", {31'h0, carry3}, 32'd0);
        chk("rst_zero", {31'h0, zero3}, 32'd0);
        chk("rst_in_ready", {31'h0, in_ready3}, 32'd1);
        chk("rst_in_ready1", {31'h0, in_ready1}, 32'd1);
        rst = 1'b0;
        wait_cycles(1);

        // Op sweep, no stall
        lat3_chk = 1'b1;
        send3(c_ADD,  8'hF0, 8'h20, 8'h10, 1'b1, 1'b0);
        send3(c_SUB,  8'h05, 8'h07, 8'hFE, 1'b1, 1'b0);
        send3(c_SUB,  8'h07, 8'h07, 8'h00, 1'b0, 1'b1);
        send3(c_AND,  8'h3C, 8'h0F, 8'h0C, 1'b0, 1'b0);
        send3(c_OR,   8'h30, 8'h05, 8'h35, 1'b0, 1'b0);
        send3(c_XOR,  8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0);
        send3(c_PASS, 8'hA5, 8'h5A, 8'hA5, 1'b0, 1'b0);
        send3(c_SHL,  8'h81, 8'h00, 8'h02, 1'b1, 1'b0);
        send3(c_RSV,  8'h12, 8'h34, 8'h00, 1'b0, 1'b1);
        send3(c_ADD,  8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        idle3();
        wait_cycles(6);
        chk("drain_sweep", q3.size(), 32'd0);

        // Throughput: a=i, b=1 back to back
        for (int i = 0; i < 10; i++) begin
            send3(c_ADD, 8'(i), 8'h01, 8'(i + 1), 1'b0, 1'b0);
        end
        idle3();
        wait_cycles(6);
        chk("drain_tput", q3.size(), 32'd0);

        // Backpressure: exactly three beats absorbed, output held, ready passes through
        lat3_chk = 1'b0;
        out_ready3 = 1'b0;
        base = acc3;
        fork
            begin
                send3(c_ADD, 8'h11, 8'h01, 8'h12, 1'b0, 1'b0);
                send3(c_ADD, 8'h22, 8'h01, 8'h23, 1'b0, 1'b0);
                send3(c_ADD, 8'h33, 8'h01, 8'h34, 1'b0, 1'b0);
                send3(c_ADD, 8'h44, 8'h01, 8'h45, 1'b0, 1'b0);
                send3(c_ADD, 8'h55, 8'h01, 8'h56, 1'b0, 1'b0);
                idle3();
            end
            begin
                wait_cycles(8);
                @(negedge clk);
                chk("bp_accepted", acc3 - base, 32'd3);
                chk("bp_in_ready", {31'h0, in_ready3}, 32'd0);
                chk("bp_out_valid", {31'h0, out_valid3}, 32'd1);
                chk("bp_hold_result", {24'h0, result3}, 32'h12);
                wait_cycles(2);
                chk("bp_hold_result2", {24'h0, result3}, 32'h12);
                chk("bp_hold_valid2", {31'h0, out_valid3}, 32'd1);
                out_ready3 = 1'b1;
                #1;
                chk("bp_ready_passthru", {31'h0, in_ready3}, 32'd1);
            end
        join
        wait_cycles(8);
        chk("drain_bp", q3.size(), 32'd0);

        // Bubbles collapse under stall
        out_ready3 = 1'b0;
        base = acc3;
        fork
            begin
                send3(c_XOR, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
                idle3(); wait_cycles(1);
                send3(c_OR, 8'h40, 8'h04, 8'h44, 1'b0, 1'b0);
                idle3(); wait_cycles(1);
                send3(c_SUB, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);
                send3(c_PASS, 8'h77, 8'h00, 8'h77, 1'b0, 1'b0);
                idle3();
            end
            begin
                wait_cycles(10);
                @(negedge clk);
                chk("bub_accepted", acc3 - base, 32'd3);
                chk("bub_in_ready", {31'h0, in_ready3}, 32'd0);
                chk("bub_head", {24'h0, result3}, 32'h03);
                @(posedge clk); #1;
                out_ready3 = 1'b1;
            end
        join
        wait_cycles(8);
        chk("drain_bub", q3.size(), 32'd0);

        // Reset with two beats in flight
        send3(c_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);
        send3(c_ADD, 8'h02, 8'h02, 8'h04, 1'b0, 1'b0);
        idle3();
        rst = 1'b1;
        q3.delete();
        q1.delete();
        #1;
        chk("mid_rst_out_valid", {31'h0, out_valid3}, 32'd0);
        chk("mid_rst_result", {24'h0, result3}, 32'd0);
        chk("mid_rst_carry", {31'h0, carry3}, 32'd0);
        chk("mid_rst_zero", {31'h0, zero3}, 32'd0);
        chk("mid_rst_in_ready", {31'h0, in_ready3}, 32'd1);
        wait_cycles(2);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_stale_beat", {31'h0, out_valid3}, 32'd0);
        end
        @(posedge clk); #1;

        // Single-stage, 16-bit instance
        lat1_chk = 1'b1;
        send1(c_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
        send1(c_SUB, 16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1'b0);
        idle1();
        wait_cycles(3);
        chk("drain1_a", q1.size(), 32'd0);

        lat1_chk = 1'b0;
        out_ready1 = 1'b0;
        send1(c_ADD, 16'h1000, 16'h0001, 16'h1001, 1'b0, 1'b0);
        fork
            begin
                send1(c_ADD, 16'h2000, 16'h0001, 16'h2001, 1'b0, 1'b0);
                send1(c_ADD, 16'h3000, 16'h0001, 16'h3001, 1'b0, 1'b0);
                send1(c_SHL, 16'h8000, 16'h0000, 16'h0000, 1'b1, 1'b1);
                idle1();
            end
            begin
                @(negedge clk);
                chk("s1_full_in_ready", {31'h0, in_ready1}, 32'd0);
                chk("s1_full_out_valid", {31'h0, out_valid1}, 32'd1);
                @(posedge clk); #1;
                out_ready1 = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("s1_push_pop", {29'h0, out_valid1, in_ready1, in_valid1}, 32'd7);
                end
            end
        join
        wait_cycles(4);
        chk("drain1_b", q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
